// File: rtl/seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_mux
// Brief    : Multiplexed display scanner feeding a 4-bit to 7-segment decoder.
//            Time-slices a DIGITS-nibble value one digit per refresh slot,
//            drives active-low digit enables with a dark guard band at the
//            start of each slot, and commits newly loaded values only at
//            frame boundaries so a frame never mixes old and new digits.
//            Optional macro SEG_LZ_BLANK_EN enables leading-zero blanking.
// Revision : 1.0  initial release
// ============================================================================
module seg_scan_mux #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   din,
    input  logic                  load,
    output logic                  ready,
    output logic [3:0]            nibble,
    output logic [DIGITS-1:0]     dig_n,
    output logic                  frame_tick
);

    localparam int              PW          = $clog2(REFRESH_DIV);
    localparam int              IW          = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0]   C_PRE_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0]   C_GUARD     = PW'(GUARD);
    localparam logic [IW-1:0]   C_IDX_LAST  = IW'(DIGITS - 1);

    logic [PW-1:0]          r_pre;
    logic [IW-1:0]          r_idx;
    logic [4*DIGITS-1:0]    r_shadow;
    logic [4*DIGITS-1:0]    r_active;
    logic                   r_pending;

    logic                   w_slot_end;
    logic                   w_frame_wrap;
    logic                   w_blank;
    logic [DIGITS-1:0]      w_sel_n;
    logic [3:0]             w_nib;

    assign w_slot_end   = (r_pre == C_PRE_LAST);
    assign w_frame_wrap = w_slot_end && (r_idx == C_IDX_LAST);
    assign ready        = ~r_pending;

    // Prescaler and slot index: idx steps once per REFRESH_DIV cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_pre <= '0;
            r_idx <= (r_idx == C_IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // Load handshake and frame-aligned commit; a commit takes priority, and
    // a load landing on a wrap with nothing pending waits for the next wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
        end else if (w_frame_wrap && r_pending) begin
            r_active  <= r_shadow;
            r_pending <= 1'b0;
        end else if (load && !r_pending) begin
            r_shadow  <= din;
            r_pending <= 1'b1;
        end
    end

`ifdef SEG_LZ_BLANK_EN
    // w_zero_from[i] is set when active digits i..DIGITS-1 are all zero
    logic [DIGITS-1:0] w_zero_from;

    for (genvar i = 0; i < DIGITS; i++) begin : g_lz
        if (i == DIGITS - 1) begin : g_top
            assign w_zero_from[i] = (r_active[4*i +: 4] == 4'h0);
        end else begin : g_mid
            assign w_zero_from[i] = (r_active[4*i +: 4] == 4'h0) && w_zero_from[i+1];
        end
    end

    // Digit 0 is never blanked so a zero value still shows one "0"
    assign w_blank = (r_idx != '0) && w_zero_from[r_idx];
`else
    assign w_blank = 1'b0;
`endif

    assign w_nib   = r_active[{r_idx, 2'b00} +: 4];
    assign w_sel_n = ~(DIGITS'(1) << r_idx);

    // Registered display outputs, one cycle behind the scan position
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nibble     <= 4'h0;
            dig_n      <= '1;
            frame_tick <= 1'b0;
        end else begin
            nibble     <= w_nib;
            dig_n      <= ((r_pre < C_GUARD) || w_blank) ? '1 : w_sel_n;
            frame_tick <= w_frame_wrap;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_mux
// Brief    : Self-checking bench for seg_scan_mux (DIGITS=4, REFRESH_DIV=8,
//            GUARD=2). Table-driven frame checks plus directed sequences for
//            rejected loads, load on the wrap cycle, reset and tick timing.
// Revision : 1.0  initial release
// ============================================================================
module tb_seg_scan_mux;

    localparam int DIGITS      = 4;
    localparam int REFRESH_DIV = 8;
    localparam int GUARD       = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic        load;
    logic        ready;
    logic [3:0]  nibble;
    logic [3:0]  dig_n;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;

    seg_scan_mux #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .GUARD       (GUARD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .load       (load),
        .ready      (ready),
        .nibble     (nibble),
        .dig_n      (dig_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // One record per displayed value: per-slot nibble and lit dig_n mask
    typedef struct {
        logic [15:0] din;
        logic [15:0] nibs;
        logic [15:0] dns;
    } vec_t;

    vec_t vecs[6];
    vec_t v5678;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until frame_tick is seen; optionally ready must hold a value
    task automatic wait_tick(input bit chk_rdy, input logic er);
        bit found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            if (frame_tick) found = 1'b1;
            else if (chk_rdy) chk("ready_wait", {15'd0, ready}, {15'd0, er});
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL frame_tick_timeout: got none expected pulse within 40 cycles");
        end
    endtask

    // Called on a frame_tick cycle; checks the following 32 display cycles
    task automatic check_frame(input vec_t v, input logic er);
        int s;
        int p;
        logic [3:0] exp_dn;
        for (int c = 0; c < 32; c++) begin
            step();
            s = c / 8;
            p = c % 8;
            exp_dn = (p < GUARD) ? 4'hF : v.dns[4*s +: 4];
            chk("nibble", {12'd0, nibble}, {12'd0, v.nibs[4*s +: 4]});
            chk("dig_n", {12'd0, dig_n}, {12'd0, exp_dn});
            chk("frame_tick", {15'd0, frame_tick}, {15'd0, (c == 31)});
            chk("ready", {15'd0, ready}, {15'd0, ((c == 31) ? 1'b1 : er)});
        end
    endtask

    // Never more than one cathode enabled in any cycle
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ($countones(~dig_n) > 1) begin
                errors++;
                $display("FAIL onehot_dig_n: got %b expected at most one low bit", dig_n);
            end
        end
    end

    initial begin
        int tcnt;
        int tpos;

        vecs[0] = '{16'h1234, 16'h1234, 16'h7BDE};
        vecs[1] = '{16'hF00F, 16'hF00F, 16'h7BDE};
        vecs[2] = '{16'h8421, 16'h8421, 16'h7BDE};
`ifdef SEG_LZ_BLANK_EN
        vecs[3] = '{16'h0070, 16'h0070, 16'hFFDE};
        vecs[4] = '{16'h0A00, 16'h0A00, 16'hFBDE};
        vecs[5] = '{16'h0000, 16'h0000, 16'hFFFE};
`else
        vecs[3] = '{16'h0070, 16'h0070, 16'h7BDE};
        vecs[4] = '{16'h0A00, 16'h0A00, 16'h7BDE};
        vecs[5] = '{16'h0000, 16'h0000, 16'h7BDE};
`endif
        v5678 = '{16'h5678, 16'h5678, 16'h7BDE};

        // Power-on reset
        rst  = 1'b1;
        load = 1'b0;
        din  = 16'h0;
        #3;
        chk("rst_dig_n", {12'd0, dig_n}, 16'h000F);
        chk("rst_nibble", {12'd0, nibble}, 16'h0000);
        chk("rst_ready", {15'd0, ready}, 16'h0001);
        chk("rst_tick", {15'd0, frame_tick}, 16'h0000);
        step();
        step();
        rst = 1'b0;
        wait_tick(1'b1, 1'b1);

        // Table: load each value, expect it from the next frame onward
        for (int i = 0; i < 6; i++) begin
            din  = vecs[i].din;
            load = 1'b1;
            step();
            load = 1'b0;
            chk("ready_after_load", {15'd0, ready}, 16'h0000);
            wait_tick(1'b1, 1'b0);
            chk("ready_at_commit", {15'd0, ready}, 16'h0001);
            check_frame(vecs[i], 1'b1);
        end

        // Rejected load while a value is pending
        din  = 16'h1234;
        load = 1'b1;
        step();
        chk("rej_ready0", {15'd0, ready}, 16'h0000);
        din = 16'hABCD;
        step();
        load = 1'b0;
        chk("rej_ready_still0", {15'd0, ready}, 16'h0000);
        wait_tick(1'b1, 1'b0);
        chk("rej_ready1", {15'd0, ready}, 16'h0001);
        check_frame(vecs[0], 1'b1);

        // Load on the internal frame-wrap cycle: shown one frame later
        for (int k = 0; k < 31; k++) step();
        chk("wrap_ready_before", {15'd0, ready}, 16'h0001);
        din  = 16'h5678;
        load = 1'b1;
        step();
        load = 1'b0;
        chk("wrap_tick", {15'd0, frame_tick}, 16'h0001);
        chk("wrap_pending", {15'd0, ready}, 16'h0000);
        check_frame(vecs[0], 1'b0);
        check_frame(v5678, 1'b1);

        // Mid-frame asynchronous reset with a value pending
        din  = 16'h8421;
        load = 1'b1;
        step();
        load = 1'b0;
        for (int k = 0; k < 10; k++) step();
        chk("pre_rst_lit", {12'd0, dig_n}, 16'h000D);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_dig_n", {12'd0, dig_n}, 16'h000F);
        chk("arst_nibble", {12'd0, nibble}, 16'h0000);
        chk("arst_ready", {15'd0, ready}, 16'h0001);
        chk("arst_tick", {15'd0, frame_tick}, 16'h0000);
        step();
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk("post_rst_dig_n", {12'd0, dig_n}, 16'h000E);
        chk("post_rst_nibble", {12'd0, nibble}, 16'h0000);
        tcnt = 0;
        for (int k = 0; k < 28; k++) begin
            step();
            if (frame_tick) tcnt++;
        end
        chk("post_rst_no_tick", 16'(tcnt), 16'd0);
        step();
        chk("post_rst_first_tick", {15'd0, frame_tick}, 16'h0001);
        check_frame(vecs[5], 1'b1);

        // Tick period and width over 1000 frames
        for (int f = 0; f < 1000; f++) begin
            tcnt = 0;
            tpos = 0;
            for (int k = 1; k <= 32; k++) begin
                step();
                if (frame_tick) begin
                    tcnt++;
                    tpos = k;
                end
            end
            chk("tick_count", 16'(tcnt), 16'd1);
            chk("tick_pos", 16'(tpos), 16'd32);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
